// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 raster timing, coordinate width and sync polarity
// shared by the VGA sync generator and its axis counters.
package vga_timing_pkg;
  localparam int H_VISIBLE = 640;
  localparam int H_FP      = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BP      = 48;
  localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

  localparam int V_VISIBLE = 480;
  localparam int V_FP      = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BP      = 33;
  localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam int COORD_W = 10;

  localparam logic SYNC_ACTIVE = 1'b0;

  function automatic logic sync_level(input logic in_sync);
    return in_sync ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  endfunction
endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping counter plus sync/visible decode of the value
// the counter is about to take, so the parent can register them in step.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int TOTAL      = H_TOTAL,
  parameter int VISIBLE    = H_VISIBLE,
  parameter int SYNC_START = H_VISIBLE + H_FP,
  parameter int SYNC_END   = H_VISIBLE + H_FP + H_SYNC - 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  output logic [COORD_W-1:0] count,
  output logic               wrap,
  output logic               in_sync,
  output logic               in_visible
);
  localparam logic [COORD_W-1:0] LAST = COORD_W'(TOTAL - 1);
  localparam logic [COORD_W-1:0] VIS  = COORD_W'(VISIBLE);
  localparam logic [COORD_W-1:0] SS   = COORD_W'(SYNC_START);
  localparam logic [COORD_W-1:0] SE   = COORD_W'(SYNC_END);

  logic [COORD_W-1:0] count_d;

  always_comb begin
    count_d = count;
    if (en) count_d = (count == LAST) ? '0 : count + 1'b1;
  end

  assign wrap       = en && (count == LAST);
  assign in_sync    = (count_d >= SS) && (count_d <= SE);
  assign in_visible = (count_d < VIS);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) count <= '0;
    else        count <= count_d;
  end
endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: H/V axis counters advanced by pix_tick,
// registered sync/visible outputs aligned with the presented coordinates.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE = vga_timing_pkg::H_VISIBLE,
  parameter int H_FP      = vga_timing_pkg::H_FP,
  parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
  parameter int H_BP      = vga_timing_pkg::H_BP,
  parameter int V_VISIBLE = vga_timing_pkg::V_VISIBLE,
  parameter int V_FP      = vga_timing_pkg::V_FP,
  parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
  parameter int V_BP      = vga_timing_pkg::V_BP
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pix_tick,
  output logic               hsync,
  output logic               vsync,
  output logic               video_on,
  output logic [COORD_W-1:0] pixel_x,
  output logic [COORD_W-1:0] pixel_y,
  output logic               line_start,
  output logic               frame_start
);
  logic h_wrap, h_sync, h_vis;
  logic v_wrap, v_sync, v_vis;

  vga_axis_counter #(
    .TOTAL     (H_VISIBLE + H_FP + H_SYNC + H_BP),
    .VISIBLE   (H_VISIBLE),
    .SYNC_START(H_VISIBLE + H_FP),
    .SYNC_END  (H_VISIBLE + H_FP + H_SYNC - 1)
  ) u_h (
    .clk       (clk),
    .reset     (reset),
    .en        (pix_tick),
    .count     (pixel_x),
    .wrap      (h_wrap),
    .in_sync   (h_sync),
    .in_visible(h_vis)
  );

  vga_axis_counter #(
    .TOTAL     (V_VISIBLE + V_FP + V_SYNC + V_BP),
    .VISIBLE   (V_VISIBLE),
    .SYNC_START(V_VISIBLE + V_FP),
    .SYNC_END  (V_VISIBLE + V_FP + V_SYNC - 1)
  ) u_v (
    .clk       (clk),
    .reset     (reset),
    .en        (h_wrap),
    .count     (pixel_y),
    .wrap      (v_wrap),
    .in_sync   (v_sync),
    .in_visible(v_vis)
  );

  // Reset levels match position (0,0): syncs idle, inside the visible area.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hsync       <= ~SYNC_ACTIVE;
      vsync       <= ~SYNC_ACTIVE;
      video_on    <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= h_wrap;
      frame_start <= h_wrap && v_wrap;
      if (pix_tick) begin
        hsync    <= sync_level(h_sync);
        vsync    <= sync_level(v_sync);
        video_on <= h_vis && v_vis;
      end
    end
  end
endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench: a default-timing instance for line behaviour and a
// shrunken-timing instance so whole frames fit in a short run.
module tb_vga_sync_gen;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic tick_a = 1'b0, tick_b = 1'b0;
  logic a_hs, a_vs, a_von, a_ls, a_fs, b_hs, b_vs, b_von, b_ls, b_fs;
  logic [9:0] a_x, a_y, b_x, b_y;

  always #5 clk = ~clk;

  vga_sync_gen u_big (
    .clk(clk), .reset(reset), .pix_tick(tick_a), .hsync(a_hs), .vsync(a_vs),
    .video_on(a_von), .pixel_x(a_x), .pixel_y(a_y), .line_start(a_ls), .frame_start(a_fs)
  );

  // H: 8/2/3/2 -> total 15, sync x 10..12. V: 4/1/2/1 -> total 8, sync y 5..6.
  vga_sync_gen #(
    .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_VISIBLE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) u_small (
    .clk(clk), .reset(reset), .pix_tick(tick_b), .hsync(b_hs), .vsync(b_vs),
    .video_on(b_von), .pixel_x(b_x), .pixel_y(b_y), .line_start(b_ls), .frame_start(b_fs)
  );

  logic sel = 1'b0;
  wire [9:0] px  = sel ? b_x   : a_x;
  wire [9:0] py  = sel ? b_y   : a_y;
  wire       phs = sel ? b_hs  : a_hs;
  wire       pvs = sel ? b_vs  : a_vs;
  wire       pvo = sel ? b_von : a_von;
  wire       pls = sel ? b_ls  : a_ls;
  wire       pfs = sel ? b_fs  : a_fs;

  typedef struct {
    logic [9:0] x, y;
    logic hs, vs, von, ls, fs, tk;
  } exp_t;
  exp_t q[$];

  int errors = 0, checks = 0;
  int ht, hv, hs0, hs1, vt, vv, vs0, vs1;
  int mx = 0, my = 0;
  logic mls = 1'b0, mfs = 1'b0;
  int n_hslow, n_vslow, n_ls, n_fs;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // Monitor: one expected entry per clk, compared half a cycle after the edge.
  exp_t e;
  always @(negedge clk) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (px !== e.x || py !== e.y || phs !== e.hs || pvs !== e.vs ||
          pvo !== e.von || pls !== e.ls || pfs !== e.fs) begin
        errors++;
        $display("FAIL cycle sel=%0d t=%0t: got x=%0d y=%0d hs=%b vs=%b von=%b ls=%b fs=%b want x=%0d y=%0d hs=%b vs=%b von=%b ls=%b fs=%b",
                 sel, $time, px, py, phs, pvs, pvo, pls, pfs,
                 e.x, e.y, e.hs, e.vs, e.von, e.ls, e.fs);
      end
      if (e.tk) begin
        if (!phs) n_hslow++;
        if (!pvs) n_vslow++;
      end
      if (pls) n_ls++;
      if (pfs) n_fs++;
    end
  end

  task automatic step(input logic t);
    tick_a = t & ~sel;
    tick_b = t & sel;
    @(posedge clk);
    #1;
    mls = 1'b0;
    mfs = 1'b0;
    if (!reset) begin
      mx = 0;
      my = 0;
    end else if (t) begin
      if (mx == ht - 1) begin
        mx  = 0;
        mls = 1'b1;
        if (my == vt - 1) begin
          my  = 0;
          mfs = 1'b1;
        end else my++;
      end else mx++;
    end
    q.push_back('{x: 10'(mx), y: 10'(my),
                  hs: !(mx >= hs0 && mx <= hs1), vs: !(my >= vs0 && my <= vs1),
                  von: (mx < hv && my < vv), ls: mls, fs: mfs, tk: t});
    tick_a = 1'b0;
    tick_b = 1'b0;
  endtask

  task automatic drain();
    repeat (2) @(negedge clk);
    #1;
    if (q.size() != 0) chk("drain", q.size(), 0);
  endtask

  task automatic clr();
    n_hslow = 0; n_vslow = 0; n_ls = 0; n_fs = 0;
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_x"}, px, 0);
    chk({tag, "_y"}, py, 0);
    chk({tag, "_hs"}, phs, 1);
    chk({tag, "_vs"}, pvs, 1);
    chk({tag, "_von"}, pvo, 1);
    chk({tag, "_ls"}, pls, 0);
    chk({tag, "_fs"}, pfs, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    sel = 1'b0;
    ht = 800; hv = 640; hs0 = 656; hs1 = 751;
    vt = 525; vv = 480; vs0 = 490; vs1 = 491;
    clr();

    // Reset held while ticks arrive: nothing moves, no pulses.
    repeat (5) step(1'b1);
    drain();
    chk_rst("hold");
    chk("hold_pulses", n_ls + n_fs, 0);

    reset = 1'b1;
    step(1'b1);
    drain();
    chk("first_tick_x", a_x, 1);

    // Horizontal sweep with 1-in-4 ticks, starting from x=1.
    clr();
    repeat (638) begin step(1'b1); repeat (3) step(1'b0); end
    drain();
    chk("x639_von", a_von, 1);
    step(1'b1); repeat (3) step(1'b0);
    drain();
    chk("x640_x", a_x, 640);
    chk("x640_von", a_von, 0);
    repeat (160) begin step(1'b1); repeat (3) step(1'b0); end
    drain();
    chk("wrap_x", a_x, 0);
    chk("wrap_y", a_y, 1);
    chk("line_hslow", n_hslow, 96);
    chk("line_ls", n_ls, 1);
    chk("line_fs", n_fs, 0);

    // Random gaps then back-to-back ticks: 150 + 1000 ticks from (0,1).
    repeat (150) begin
      step(1'b1);
      repeat ($urandom_range(0, 20)) step(1'b0);
    end
    repeat (1000) step(1'b1);
    drain();
    chk("stall_x", a_x, 350);
    chk("stall_y", a_y, 2);

    repeat (350) step(1'b1);
    drain();
    chk("pre_rst_hs", a_hs, 0);
    chk("pre_rst_von", a_von, 0);
    reset = 1'b0;
    #1;
    chk_rst("async_big");
    repeat (3) step(1'b1);
    reset = 1'b1;
    clr();
    step(1'b1);
    drain();
    chk("rel_big_x", a_x, 1);
    chk("rel_big_fs", n_fs, 0);

    // Shrunken timing: whole frames with a tick on every clk.
    sel = 1'b1;
    ht = 15; hv = 8; hs0 = 10; hs1 = 12;
    vt = 8;  vv = 4; vs0 = 5;  vs1 = 6;
    reset = 1'b0;
    step(1'b0);
    reset = 1'b1;
    clr();
    repeat (120) step(1'b1);
    drain();
    chk("frame_x", b_x, 0);
    chk("frame_y", b_y, 0);
    chk("frame_ls", n_ls, 8);
    chk("frame_fs", n_fs, 1);
    chk("frame_vslow", n_vslow, 30);
    chk("frame_hslow", n_hslow, 24);

    repeat (50) step(1'b1);
    drain();
    chk("mid_x", b_x, 5);
    chk("mid_y", b_y, 3);
    reset = 1'b0;
    #1;
    chk_rst("async_small");
    repeat (2) step(1'b1);
    reset = 1'b1;
    clr();
    repeat (119) step(1'b1);
    drain();
    chk("partial_fs", n_fs, 0);
    step(1'b1);
    drain();
    chk("refr_fs", n_fs, 1);
    chk("refr_ls", n_ls, 8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
